uart_tx_byte_feeder: RTL

- Buffers bytes from a host write port in a synchronous FIFO and feeds them one at a time to the downstream UART byte transmitter (8N1 serializer with start/busy/done handshake).
- Sits directly upstream of the byte transmitter, between the bus-slave register logic and the serializer.
- Back-to-back bytes go out with no host involvement; the host only watches full/level/overflow.

---
 rtl/uart_tx_byte_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_byte_feeder.sv
// uart_tx_byte_feeder: host write FIFO that feeds one byte at a time to a
// downstream 8N1 byte transmitter using its start/busy/done handshake.
module uart_tx_byte_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_wrData,
  input  logic                  i_wrEn,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [7:0]            o_txData,
  output logic                  o_txStart,
  input  logic                  i_txBusy,
  input  logic                  i_txDone
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            full_c, empty_c, wr_accept_c, pop_c;

  // Flags decode the registered count only, so a same-cycle write is never
  // visible to the pop logic.
  assign full_c      = (count_q == CW'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign wr_accept_c = i_wrEn & ~full_c & ~i_flush;

  // Handshake FSM: pop and start pulse on IDLE->START, then track busy/done.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c && !i_txBusy && !i_flush) begin
          pop_c      = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rd_q];
          state_d    = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (i_txBusy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_txDone) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer/count/overflow next state; flush overrides everything.
  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_flush) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (i_wrEn && full_c) overflow_d = 1'b1;
      if (wr_accept_c)      wr_d = wr_q + PW'(1);
      if (pop_c)            rd_d = rd_q + PW'(1);
      case ({wr_accept_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Storage array; contents are don't-care until written so it has no reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept_c) mem_q[wr_q] <= i_wrData;
  end

  assign o_full     = full_c;
  assign o_empty    = empty_c;
  assign o_level    = count_q;
  assign o_overflow = overflow_q;
  assign o_txData   = tx_data_q;
  assign o_txStart  = tx_start_q;

endmodule
